// File: rtl/touch_paint_writer.sv
// touch_paint_writer: debounces touchpad samples on a prescaled tick, maps them to pixels and
// writes a single dot, or a 3x3 brush stamp when TOUCH_BRUSH_EN is defined.
module touch_paint_writer #(
  parameter int SAMPLE_DIV = 1024,
  parameter int Z_THRESH   = 256,
  parameter int DEBOUNCE   = 4,
  parameter int X_OFF      = 150,
  parameter int Y_OFF      = 300,
  parameter int X_SHIFT    = 3,
  parameter int Y_SHIFT    = 4,
  parameter int X_MAX      = 479,
  parameter int Y_MAX      = 271
) (
  input  logic        cclk,
  input  logic        reset,
  input  logic [11:0] touch_x,
  input  logic [11:0] touch_y,
  input  logic [11:0] touch_z,
  input  logic [8:0]  pen_color,
  input  logic        clear_screen,
  output logic        wr_ena,
  output logic [8:0]  wr_x,
  output logic [8:0]  wr_y,
  output logic [8:0]  wr_data,
  output logic        pen_down
);

  localparam int TW = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, MAP = 2'd1, PAINT = 2'd2} state_t;

  state_t        state_r;
  logic [TW-1:0] tick_cnt_r;
  logic [3:0]    press_cnt_r;
  logic [3:0]    press_cnt_nx_s;
  logic          pen_down_nx_s;
  logic          tick_s;
  logic          pressed_s;
  logic          last_valid_r;
  logic          last_slot_s;
  logic          in_bounds_s;
  logic [8:0]    cur_x_r, cur_y_r, last_x_r, last_y_r;
  logic [8:0]    map_x_s, map_y_s, pix_x_s, pix_y_s;

  function automatic logic [8:0] map_axis(input logic [11:0] raw, input int off,
                                          input int shift, input int max_v);
    logic signed [12:0] diff;
    logic [11:0]        scaled;
    diff   = $signed({1'b0, raw}) - $signed(13'(off));
    scaled = diff[11:0] >> shift;
    if (diff[12])
      map_axis = 9'd0;
    else if (scaled > 12'(max_v))
      map_axis = 9'(max_v);
    else
      map_axis = scaled[8:0];
  endfunction

  assign tick_s    = (tick_cnt_r == TW'(SAMPLE_DIV - 1));
  assign pressed_s = (touch_z >= 12'(Z_THRESH));
  assign map_x_s   = map_axis(touch_x, X_OFF, X_SHIFT, X_MAX);
  assign map_y_s   = map_axis(touch_y, Y_OFF, Y_SHIFT, Y_MAX);

  // Free-running sample prescaler; tick_s marks its terminal count.
  always_ff @(posedge cclk) begin
    if (reset)
      tick_cnt_r <= TW'(0);
    else if (tick_s)
      tick_cnt_r <= TW'(0);
    else
      tick_cnt_r <= tick_cnt_r + TW'(1);
  end

  // Next press count and debounced pen state for this cycle's tick.
  always_comb begin
    press_cnt_nx_s = press_cnt_r;
    pen_down_nx_s  = pen_down;
    if (tick_s) begin
      if (pressed_s) begin
        if (press_cnt_r >= 4'(DEBOUNCE))
          press_cnt_nx_s = 4'(DEBOUNCE);
        else
          press_cnt_nx_s = press_cnt_r + 4'd1;
        if (press_cnt_nx_s == 4'(DEBOUNCE))
          pen_down_nx_s = 1'b1;
        else
          pen_down_nx_s = pen_down;
      end else begin
        press_cnt_nx_s = 4'd0;
        pen_down_nx_s  = 1'b0;
      end
    end else begin
      press_cnt_nx_s = press_cnt_r;
      pen_down_nx_s  = pen_down;
    end
  end

`ifdef TOUCH_BRUSH_EN
  localparam logic [3:0] LAST_IDX = 4'd8;

  logic [3:0]         idx_r;
  logic [3:0]         sel_idx_s;
  logic signed [10:0] bx_s, by_s;

  function automatic logic signed [10:0] col_off(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: col_off = -11'sd1;
      4'd1, 4'd4, 4'd7: col_off = 11'sd0;
      default:          col_off = 11'sd1;
    endcase
  endfunction

  function automatic logic signed [10:0] row_off(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: row_off = -11'sd1;
      4'd3, 4'd4, 4'd5: row_off = 11'sd0;
      default:          row_off = 11'sd1;
    endcase
  endfunction

  // Candidate pixel for the stamp slot about to be loaded into the write registers.
  always_comb begin
    if (state_r == PAINT)
      sel_idx_s = idx_r + 4'd1;
    else
      sel_idx_s = 4'd0;
    bx_s        = $signed({2'b00, cur_x_r}) + col_off(sel_idx_s);
    by_s        = $signed({2'b00, cur_y_r}) + row_off(sel_idx_s);
    pix_x_s     = bx_s[8:0];
    pix_y_s     = by_s[8:0];
    in_bounds_s = !bx_s[10] && (bx_s[9:0] <= 10'(X_MAX)) &&
                  !by_s[10] && (by_s[9:0] <= 10'(Y_MAX));
  end

  assign last_slot_s = (idx_r == LAST_IDX);
`else
  assign pix_x_s     = cur_x_r;
  assign pix_y_s     = cur_y_r;
  assign in_bounds_s = 1'b1;
  assign last_slot_s = 1'b1;
`endif

  // Debounce state, capture/dedupe/paint sequencing and registered write port.
  always_ff @(posedge cclk) begin
    if (reset) begin
      state_r      <= IDLE;
      press_cnt_r  <= 4'd0;
      pen_down     <= 1'b0;
      last_valid_r <= 1'b0;
      cur_x_r      <= 9'd0;
      cur_y_r      <= 9'd0;
      last_x_r     <= 9'd0;
      last_y_r     <= 9'd0;
      wr_ena       <= 1'b0;
      wr_x         <= 9'd0;
      wr_y         <= 9'd0;
      wr_data      <= 9'd0;
`ifdef TOUCH_BRUSH_EN
      idx_r        <= 4'd0;
`endif
    end else if (clear_screen) begin
      state_r      <= IDLE;
      press_cnt_r  <= 4'd0;
      pen_down     <= 1'b0;
      last_valid_r <= 1'b0;
      wr_ena       <= 1'b0;
    end else begin
      press_cnt_r <= press_cnt_nx_s;
      pen_down    <= pen_down_nx_s;
      wr_ena      <= 1'b0;
      if (pen_down && !pen_down_nx_s)
        last_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s && pen_down_nx_s) begin
            cur_x_r <= map_x_s;
            cur_y_r <= map_y_s;
            wr_data <= pen_color;
            state_r <= MAP;
          end
        end
        MAP: begin
          if (last_valid_r && (cur_x_r == last_x_r) && (cur_y_r == last_y_r)) begin
            state_r <= IDLE;
          end else begin
            state_r <= PAINT;
            wr_ena  <= in_bounds_s;
            wr_x    <= pix_x_s;
            wr_y    <= pix_y_s;
`ifdef TOUCH_BRUSH_EN
            idx_r   <= 4'd0;
`endif
          end
        end
        PAINT: begin
          if (last_slot_s) begin
            state_r  <= IDLE;
            last_x_r <= cur_x_r;
            last_y_r <= cur_y_r;
            // A pen lift during the stamp must not leave the spot marked as painted.
            last_valid_r <= pen_down_nx_s;
          end else begin
            wr_ena <= in_bounds_s;
            wr_x   <= pix_x_s;
            wr_y   <= pix_y_s;
`ifdef TOUCH_BRUSH_EN
            idx_r  <= idx_r + 4'd1;
`endif
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/touch_paint_writer.md
# touch_paint_writer

Converts raw touchpad samples (`touch_x/y/z` from `touchpad_controller`) into pixel writes on the `tft_driver` write port (`wr_ena/wr_x/wr_y/wr_data`). It sits between the two blocks in `main`. Samples are taken on a fixed prescaled tick. A press is recognised only after several consecutive pressed ticks, then the coordinates are calibrated, clamped and emitted as a one-pixel dot or a 3x3 brush stamp.

## Interface
- `SAMPLE_DIV`, 1024: cclk cycles per sample tick; must be ≥ 16.
- `Z_THRESH`, 256: pressed when `touch_z >= Z_THRESH`.
- `DEBOUNCE`, 4: consecutive pressed ticks required before painting (1–15).
- `X_OFF`, 150 / `Y_OFF`, 300: raw calibration offsets.
- `X_SHIFT`, 3 / `Y_SHIFT`, 4: raw-to-pixel right shifts.
- `X_MAX`, 479 / `Y_MAX`, 271: last valid pixel column/row.
- `cclk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high reset.
- `touch_x`, `touch_y`, `touch_z` in 12 each: live touchpad samples.
- `pen_color` in 9: pixel data for writes.
- `clear_screen` in 1: TFT clear in progress; suppresses painting.
- `wr_ena` out 1: one-cycle write strobe to `tft_driver`.
- `wr_x`, `wr_y` out 9 each: write address.
- `wr_data` out 9: write data.
- `pen_down` out 1: debounced touch state.

## Operation
- Tick counter runs 0..SAMPLE_DIV-1 and wraps. `tick` is asserted for the one cycle in which the count equals SAMPLE_DIV-1.
- Press counter, 4-bit and saturating at DEBOUNCE:
  - On a tick with the sample pressed: counter increments.
  - On a tick with the sample not pressed: counter clears and `pen_down` drops.
  - When the counter reaches DEBOUNCE, `pen_down` is set.
- Mapping (13-bit signed arithmetic):
  - `dx = touch_x - X_OFF`. If `dx < 0`, px = 0. Otherwise px = `dx >> X_SHIFT`, clamped to X_MAX.
  - Y is computed the same way with `Y_OFF`, `Y_SHIFT` and `Y_MAX`.
- FSM states:
  - `IDLE`: on a tick where `pen_down` is (or becomes) 1, latch the mapped px/py into `cur_x/cur_y` and go to `MAP`.
  - `MAP`: compare against `last_x/last_y`.
    - If equal and `last_valid` is set, return to `IDLE` (deduplication; no writes).
    - Otherwise go to `PAINT` with stamp index 0.
  - `PAINT`: emits the stamp (see Configuration), one candidate pixel per cycle. After the final index, update `last_x/last_y`, set `last_valid`, and return to `IDLE`.
- `last_valid` clears whenever `pen_down` falls, so lifting the pen and retouching the same spot repaints it.
- While `clear_screen` is 1:
  - FSM is forced to `IDLE`.
  - Press counter, `pen_down` and `last_valid` clear.
  - `wr_ena` is 0.
- Ticks arriving in `MAP`/`PAINT` are ignored for coordinate capture but still update the press counter. If a tick drops `pen_down` mid-stamp, the stamp still completes.
- Brush pixels outside 0..X_MAX / 0..Y_MAX hold `wr_ena` at 0 for that cycle but still consume the slot, so stamp length is constant.
- `wr_data` is `pen_color`, registered at `MAP` entry and held through `PAINT`.

## Timing
- Reset values (all outputs and state):
  - Outputs: `wr_ena` = 0, `wr_x` = `wr_y` = `wr_data` = 0, `pen_down` = 0.
  - Internal: FSM `IDLE`, tick and press counters 0, `last_valid` = 0.
- If reset is asserted mid-`PAINT`, `wr_ena` is 0 from the next edge. No partial stamp resumes.
- Tick at cycle T with `pen_down` → `MAP` at T+1 → first `wr_ena` at T+2.
- Writes occupy T+2..T+2+N-1, where N = 9 with the brush and N = 1 without it.
- `wr_ena` is high for exactly one cycle per pixel, with `wr_x/wr_y/wr_data` valid in the same cycle. `tft_driver` accepts one write per cycle, so no backpressure is needed.
- `clear_screen` takes effect on the next edge.

## Configuration
- `TOUCH_BRUSH_EN` defined:
  - N = 9.
  - Pixels are emitted row-major at offsets (-1,-1), (0,-1), (+1,-1), (-1,0), … (+1,+1) around `cur_x/cur_y`.
  - Each offset pixel is bounds-checked as described in Operation.
- `TOUCH_BRUSH_EN` undefined:
  - N = 1.
  - Only (`cur_x`, `cur_y`) is written.
  - The stamp index register and the bounds logic are removed.

## Test plan
- Dot write: `touch_x` = 950, `touch_y` = 1900, `touch_z` = 1024 held for 4 ticks → `pen_down` = 1. Centre write at (100,100) with `wr_data` = `pen_color`. With brush: 9 writes covering x,y in 99..101, first write 2 cycles after the 4th tick.
- Debounce: `touch_z` = 1024 for 3 ticks, then 100 for one tick, then 1024 for 3 ticks → no `wr_ena` ever, and `pen_down` stays 0.
- Clamp: `touch_x` = 100 → px 0; `touch_x` = 4095 → px 479; `touch_y` = 200 → py 0. With brush at (0,0): only 4 `wr_ena` pulses in the 9-cycle stamp.
- Dedupe: a steady press at the same coordinates for 10 ticks → exactly one stamp. Lift for 1 tick, then re-press 4 ticks → a second stamp.
- Clear and reset: assert `clear_screen` during `PAINT` → `wr_ena` is 0 the next cycle, and a new stamp needs 4 fresh pressed ticks. Assert `reset` mid-stamp → all outputs read 0 the next cycle.
